// File: rtl/csa_shared_seq.sv
// csa_shared_seq: round-robin sequencer sharing one 32-bit carry-select
// adder between two requesters; multi-word add/sub, one word per cycle.

module csa_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    // upper half precomputed for both carries, selected by the low carry
    always_comb begin
        lo    = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, c_in};
        hi0   = {1'b0, a[31:16]} + {1'b0, b[31:16]};
        hi1   = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
        sum   = {lo[16] ? hi1[15:0] : hi0[15:0], lo[15:0]};
        c_out = lo[16] ? hi1[16] : hi0[16];
    end
endmodule

module csa_shared_seq #(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [32*WORDS-1:0]   req0_a,
    input  logic [32*WORDS-1:0]   req0_b,
    input  logic                  req0_sub,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [32*WORDS-1:0]   req1_a,
    input  logic [32*WORDS-1:0]   req1_b,
    input  logic                  req1_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [32*WORDS-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf
);
    localparam int N = 32 * WORDS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic         rr_q, rr_d;
    logic         id_q, id_d;
    logic         c_q, c_d;
    logic [1:0]   k_q, k_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] sum_q, sum_d;

    logic         gnt0, gnt1;
    logic         sub_sel;
    logic [31:0]  add_a, add_b, add_s;
    logic         add_co;

    csa_32bits u_csa (
        .a     (add_a),
        .b     (add_b),
        .c_in  (c_q),
        .sum   (add_s),
        .c_out (add_co)
    );

    always_comb begin
        gnt0       = req0_valid && (!req1_valid || !rr_q);
        gnt1       = req1_valid && (!req0_valid || rr_q);
        sub_sel    = 1'b0;
        add_a      = '0;
        add_b      = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k_q == 2'(i)) begin
                add_a = a_q[32*i +: 32];
                add_b = b_q[32*i +: 32];
            end
        end
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        c_d        = c_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_ready = rst_n && gnt0;
                req1_ready = rst_n && gnt1;
                if (gnt0 || gnt1) begin
                    sub_sel = gnt1 ? req1_sub : req0_sub;
                    id_d    = gnt1;
                    a_d     = gnt1 ? req1_a : req0_a;
                    b_d     = (gnt1 ? req1_b : req0_b) ^ {N{sub_sel}};
                    c_d     = sub_sel;
                    k_d     = 2'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (k_q == 2'(i)) sum_d[32*i +: 32] = add_s;
                end
                c_d = add_co;
                if (k_q == 2'(WORDS - 1)) state_d = DONE;
                else k_d = k_q + 2'd1;
            end
            DONE: begin
                if (rsp_ready) begin
                    rr_d    = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            c_q     <= 1'b0;
            k_q     <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            c_q     <= c_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = c_q;
    assign rsp_ovf   = (a_q[N-1] == b_q[N-1]) && (sum_q[N-1] != a_q[N-1]);
endmodule

// File: tb/tb_csa_shared_seq.sv
// Scoreboard bench for csa_shared_seq: random and directed multi-word
// add/sub traffic from two requesters against a plain-arithmetic model.

module tb_csa_shared_seq;
    localparam int W = 2;
    localparam int N = 32 * W;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
    } op_t;

    typedef struct {
        logic         id;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [1:0]   vld = 2'b00;
    logic [1:0]   rdy;
    logic [N-1:0] opa [2];
    logic [N-1:0] opb [2];
    logic [1:0]   sub_in = 2'b00;
    logic         rsp_ready = 1'b0;
    logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf;
    logic [N-1:0] rsp_sum;

    csa_shared_seq #(.WORDS(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (vld[0]),
        .req0_ready (rdy[0]),
        .req0_a     (opa[0]),
        .req0_b     (opb[0]),
        .req0_sub   (sub_in[0]),
        .req1_valid (vld[1]),
        .req1_ready (rdy[1]),
        .req1_a     (opa[1]),
        .req1_b     (opb[1]),
        .req1_sub   (sub_in[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf)
    );

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   acc_cnt = 0;
    int   resp_cnt = 0;
    int   cyc = 0;
    logic m_rr = 1'b0;
    logic seen = 1'b0;
    logic rst_pend = 1'b0;
    logic rst_req = 1'b1;
    logic [1:0] drop = 2'b00;
    int   rmode = 0;

    task automatic chk(input string nm, input logic [79:0] got,
                       input logic [79:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    // monitor: grant model, response scoreboard, latency and reset checks
    always @(negedge clk) begin
        logic busy, er0, er1;
        exp_t e;
        busy = (acc_cnt != resp_cnt);
        er0  = rst_n && !busy && vld[0] && (!vld[1] || !m_rr);
        er1  = rst_n && !busy && vld[1] && (!vld[0] || m_rr);
        chk("ready", 80'(rdy), 80'({er1, er0}));
        if (rst_pend && rst_n)
            chk("reset_out",
                80'({rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum}), '0);
        if (!rst_n) begin
            sb.delete();
            resp_cnt <= 0;
            m_rr     <= 1'b0;
            seen     = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rsp: got id %0d sum %h want none",
                         rsp_id, rsp_sum);
            end else begin
                e = sb[0];
                if (!seen) begin
                    chk("latency", 80'(cyc - e.cyc), 80'(W + 1));
                    seen = 1'b1;
                end
                chk("rsp", {13'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf},
                    {13'd0, e.id, e.sum, e.cout, e.ovf});
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    seen     = 1'b0;
                    resp_cnt <= resp_cnt + 1;
                    m_rr     <= !e.id;
                end
            end
        end
        rst_pend = !rst_n;
        cyc <= cyc + 1;
    end

    function automatic op_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic s);
        op_t o;
        o.a = a;
        o.b = b;
        o.sub = s;
        return o;
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic op_t rand_op();
        return mk(pick(), pick(), 1'($urandom_range(0, 1)));
    endfunction

    task automatic present(input int i);
        op_t o;
        if (i == 0) o = q0[0];
        else o = q1[0];
        vld[i]    = 1'b1;
        opa[i]    = o.a;
        opb[i]    = o.b;
        sub_in[i] = o.sub;
    endtask

    task automatic accept(input int i);
        exp_t e;
        logic [N-1:0] a, b;
        logic s;
        logic [N:0] t;
        logic signed [N+1:0] sa, sbv, r;
        a = opa[i];
        b = opb[i];
        s = sub_in[i];
        t = {1'b0, a} + {1'b0, b};
        sa  = $signed({{2{a[N-1]}}, a});
        sbv = $signed({{2{b[N-1]}}, b});
        r = s ? sa - sbv : sa + sbv;
        e.id   = i[0];
        e.sum  = s ? a - b : a + b;
        e.cout = s ? (a >= b) : t[N];
        e.ovf  = (r[N+1:N-1] != 3'b000) && (r[N+1:N-1] != 3'b111);
        e.cyc  = cyc;
        sb.push_back(e);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        drop[i] = 1'b1;
        acc_cnt <= acc_cnt + 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rst_n = !rst_req;
        for (int i = 0; i < 2; i++) begin
            if (drop[i]) begin
                vld[i]  = 1'b0;
                opa[i]  = {$urandom, $urandom};
                opb[i]  = {$urandom, $urandom};
                drop[i] = 1'b0;
            end
        end
        if (!vld[0] && q0.size() != 0) present(0);
        if (!vld[1] && q1.size() != 0) present(1);
        case (rmode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
        @(negedge clk);
        if (!rst_n) acc_cnt <= 0;
        else begin
            for (int i = 0; i < 2; i++)
                if (vld[i] && rdy[i]) accept(i);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q0.size() != 0 || q1.size() != 0 || vld != 2'b00 ||
               sb.size() != 0) begin
            cycle();
            n++;
            if (n > budget) begin
                $display("FAIL drain: got %0d pending want 0 within %0d cycles",
                         sb.size() + q0.size() + q1.size(), budget);
                $fatal(1);
            end
        end
    endtask

    initial begin
        int n;
        opa[0] = '0;
        opa[1] = '0;
        opb[0] = '0;
        opb[1] = '0;
        repeat (2) cycle();
        rst_req = 1'b0;
        cycle();

        // fairness: both requesters held valid for four operations
        rmode = 0;
        repeat (2) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        drain(100);

        q0.push_back(mk(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0));
        drain(50);
        q1.push_back(mk(64'h5, 64'h7, 1'b1));
        drain(50);
        q1.push_back(mk(64'h7, 64'h5, 1'b1));
        drain(50);
        q0.push_back(mk(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0));
        drain(50);
        q1.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0));
        drain(50);
        q0.push_back(mk(64'h8000_0000_0000_0000, 64'h1, 1'b1));
        drain(50);

        // backpressure with a waiting request
        rmode = 2;
        q0.push_back(rand_op());
        n = 0;
        while (!rsp_valid) begin
            cycle();
            n++;
            if (n > 20) begin
                $display("FAIL bp_wait: got no rsp_valid want rsp_valid");
                $fatal(1);
            end
        end
        q1.push_back(rand_op());
        repeat (5) cycle();
        rmode = 0;
        drain(50);

        // reset while word 0 is in flight; rr was left pointing at 1
        q0.push_back(rand_op());
        drain(50);
        q0.push_back(rand_op());
        n = 0;
        while (q0.size() != 0) begin
            cycle();
            n++;
            if (n > 20) begin
                $display("FAIL rst_acc: got no accept want accept");
                $fatal(1);
            end
        end
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        repeat (6) cycle();
        q0.push_back(rand_op());
        q1.push_back(rand_op());
        drain(50);
        q1.push_back(rand_op());
        drain(50);

        rmode = 1;
        repeat (40) begin
            case ($urandom_range(0, 2))
                0: q0.push_back(rand_op());
                1: q1.push_back(rand_op());
                default: begin
                    q0.push_back(rand_op());
                    q1.push_back(rand_op());
                end
            endcase
            repeat ($urandom_range(0, 4)) cycle();
        end
        drain(3000);
        rmode = 0;
        repeat (3) cycle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
